// File: rtl/wasm_pkg.sv
// Shared WebAssembly core types: value types, operand-stack entries, frame records.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wasm_pkg;

    localparam int LOCAL_COUNT      = 16;
    localparam int CALL_STACK_DEPTH = 4;

    // Encodings follow the wasm binary format; VT_NONE marks an unused slot.
    typedef enum logic [7:0] {
        VT_NONE = 8'h00,
        VT_F64  = 8'h7C,
        VT_F32  = 8'h7D,
        VT_I64  = 8'h7E,
        VT_I32  = 8'h7F
    } valtype_t;

    typedef struct packed {
        valtype_t    vtype;
        logic [63:0] val;
    } stack_entry_t;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_POP  = 2'd1,
        FS_ZERO = 2'd2,
        FS_DONE = 2'd3
    } frame_state_t;

    typedef struct packed {
        logic [15:0] base;
        logic [7:0]  size;
    } frame_rec_t;

endpackage

// File: rtl/wasm_frame_setup_if.sv
// Bundle of call/return handshakes, operand-stack pop port, locals write port and frame status.
// Latency: n/a (wiring only).
// Backpressure: call/ret via valid/ready, operand stack via pop_req/pop_valid.
interface wasm_frame_setup_if;
    import wasm_pkg::*;

    // call / return requests
    logic                 call_valid;
    logic                 call_ready;
    logic [7:0]           call_param_count;
    logic [7:0]           call_local_count;
    valtype_t [0:31]      call_types;
    logic                 ret_valid;
    logic                 ret_ready;

    // operand stack pop port
    logic                 pop_req;
    logic                 pop_valid;
    stack_entry_t         pop_data;

    // locals store write port
    logic                 lw_en;
    logic [15:0]          lw_base_idx;
    logic [7:0]           lw_local_idx;
    stack_entry_t         lw_data;

    // frame status
    logic [15:0]          frame_base;
    logic [15:0]          next_base;
    logic [7:0]           depth;
    logic                 busy;
    logic                 done;
    logic                 err_overflow;
    logic                 err_underflow;

    // Requester / operand stack side.
    modport master (
        output call_valid, call_param_count, call_local_count, call_types, ret_valid,
        output pop_valid, pop_data,
        input  call_ready, ret_ready, pop_req,
        input  lw_en, lw_base_idx, lw_local_idx, lw_data,
        input  frame_base, next_base, depth, busy, done, err_overflow, err_underflow
    );

    // Frame sequencer side.
    modport slave (
        input  call_valid, call_param_count, call_local_count, call_types, ret_valid,
        input  pop_valid, pop_data,
        output call_ready, ret_ready, pop_req,
        output lw_en, lw_base_idx, lw_local_idx, lw_data,
        output frame_base, next_base, depth, busy, done, err_overflow, err_underflow
    );

endinterface

// File: rtl/wasm_frame_stack.sv
// LIFO of saved caller frames {base, size}; push/pop with combinational top-of-stack.
// Latency: push/pop take effect on the next clock; top is combinational from storage.
// Backpressure: none; push when full and pop when empty are ignored.
// Ports: clk, rst_n, push/push_rec, pop, top, full, empty, count.
module wasm_frame_stack
    import wasm_pkg::*;
#(
    parameter int DEPTH = CALL_STACK_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  frame_rec_t push_rec,
    input  logic       pop,
    output frame_rec_t top,
    output logic       full,
    output logic       empty,
    output logic [7:0] count
);

    localparam int PW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    frame_rec_t    mem [DEPTH];
    logic [PW-1:0] ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (ptr == PW'(DEPTH));
    assign empty   = (ptr == '0);
    assign count   = 8'(ptr);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // ptr-1 is only meaningful when non-empty; the mux hides the wrap.
    assign top = empty ? '0 : mem[IW'(ptr - 1'b1)];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[IW'(ptr)] <= push_rec;
            end
            case ({push_ok, pop_ok})
                2'b10:   ptr <= ptr + 1'b1;
                2'b01:   ptr <= ptr - 1'b1;
                default: ptr <= ptr;
            endcase
        end
    end

endmodule

// File: rtl/wasm_frame_setup.sv
// Call-frame sequencer: allocates a locals window, moves call params from the operand stack, zero-fills locals, restores on return.
// Latency: call accepted at T writes params T+1..T+P, locals T+P+1..T+P+L, done at T+P+L+1; return visible next cycle.
// Backpressure: call/ret ready only in IDLE (return wins); pop_valid low stalls the param copy with no write.
// Ports: clk, rst_n, bus (slave view of wasm_frame_setup_if: call/ret handshakes, pop port, locals write port, frame status).
module wasm_frame_setup
    import wasm_pkg::*;
#(
    parameter int MAX_DEPTH  = CALL_STACK_DEPTH,
    parameter int MAX_LOCALS = LOCAL_COUNT * CALL_STACK_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    wasm_frame_setup_if.slave bus
);

    localparam logic [16:0] MAX_LOCALS_W = 17'(MAX_LOCALS);

    frame_state_t    state, state_nxt;

    // per-call context latched on accept
    logic [15:0]     nb;
    logic [7:0]      p_cnt;
    logic [7:0]      l_cnt;
    logic [7:0]      r_cnt;      // params still to move
    logic [7:0]      j_cnt;      // next declared local to clear
    logic [0:31][7:0] types_q;

    // current frame
    logic [15:0]     frame_base_q;
    logic [7:0]      frame_size_q;

    logic            done_q;
    logic            ovf_q;
    logic            unf_q;

    // frame stack
    logic            st_push;
    logic            st_pop;
    frame_rec_t      st_top;
    logic            st_full;
    logic            st_empty;
    logic [7:0]      st_count;

    logic            idle;
    logic            call_fire;
    logic            call_reject;
    logic            call_go;
    logic            ret_fire;
    logic            ret_unf;
    logic [8:0]      pl_sum;
    logic [16:0]     base_sum;
    logic [15:0]     next_base_c;

    assign idle        = (state == FS_IDLE);
    assign next_base_c = frame_base_q + {8'h00, frame_size_q};

    // Return has priority, so a pending return masks call_ready.
    assign bus.call_ready = idle && !bus.ret_valid;
    assign bus.ret_ready  = idle && !st_empty;

    assign call_fire = bus.call_valid && bus.call_ready;
    assign ret_fire  = bus.ret_valid && bus.ret_ready;
    assign ret_unf   = idle && bus.ret_valid && st_empty;

    assign pl_sum   = {1'b0, bus.call_param_count} + {1'b0, bus.call_local_count};
    assign base_sum = {1'b0, next_base_c} + {9'h000, bus.call_param_count}
                                          + {9'h000, bus.call_local_count};

    assign call_reject = st_full || (pl_sum > 9'd32) || (base_sum > MAX_LOCALS_W);
    assign call_go     = call_fire && !call_reject;

    // The caller frame is saved as the new one is installed.
    assign st_push = (state == FS_DONE);
    assign st_pop  = ret_fire;

    wasm_frame_stack #(
        .DEPTH (MAX_DEPTH)
    ) u_stack (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (st_push),
        .push_rec ('{base: frame_base_q, size: frame_size_q}),
        .pop      (st_pop),
        .top      (st_top),
        .full     (st_full),
        .empty    (st_empty),
        .count    (st_count)
    );

    // Next state and combinational write-port drive.
    always_comb begin
        state_nxt        = state;
        bus.pop_req      = 1'b0;
        bus.lw_en        = 1'b0;
        bus.lw_base_idx  = '0;
        bus.lw_local_idx = '0;
        bus.lw_data      = '0;

        case (state)
            FS_IDLE: begin
                if (call_go) begin
                    if (bus.call_param_count != 8'd0) begin
                        state_nxt = FS_POP;
                    end else if (bus.call_local_count != 8'd0) begin
                        state_nxt = FS_ZERO;
                    end else begin
                        state_nxt = FS_DONE;
                    end
                end
            end

            FS_POP: begin
                bus.pop_req = 1'b1;
                if (bus.pop_valid) begin
                    // Top of stack is the last parameter, so fill downward.
                    bus.lw_en        = 1'b1;
                    bus.lw_base_idx  = nb;
                    bus.lw_local_idx = r_cnt - 8'd1;
                    bus.lw_data      = bus.pop_data;
                    if (r_cnt == 8'd1) begin
                        state_nxt = (l_cnt != 8'd0) ? FS_ZERO : FS_DONE;
                    end
                end
            end

            FS_ZERO: begin
                bus.lw_en            = 1'b1;
                bus.lw_base_idx      = nb;
                bus.lw_local_idx     = p_cnt + j_cnt;
                bus.lw_data.vtype    = valtype_t'(types_q[j_cnt[4:0]]);
                bus.lw_data.val      = 64'h0;
                if (j_cnt == l_cnt - 8'd1) begin
                    state_nxt = FS_DONE;
                end
            end

            FS_DONE: begin
                state_nxt = FS_IDLE;
            end

            default: begin
                state_nxt = FS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nb           <= '0;
            p_cnt        <= '0;
            l_cnt        <= '0;
            r_cnt        <= '0;
            j_cnt        <= '0;
            types_q      <= '0;
            frame_base_q <= '0;
            frame_size_q <= '0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
        end else begin
            // done is registered so it lines up with the DONE cycle.
            done_q <= (state_nxt == FS_DONE);
            ovf_q  <= call_fire && call_reject;
            unf_q  <= ret_unf;

            if (call_go) begin
                nb      <= next_base_c;
                p_cnt   <= bus.call_param_count;
                l_cnt   <= bus.call_local_count;
                r_cnt   <= bus.call_param_count;
                j_cnt   <= '0;
                types_q <= bus.call_types;
            end

            if (state == FS_POP && bus.pop_valid) begin
                r_cnt <= r_cnt - 8'd1;
            end

            if (state == FS_ZERO) begin
                j_cnt <= j_cnt + 8'd1;
            end

            if (state == FS_DONE) begin
                frame_base_q <= nb;
                frame_size_q <= p_cnt + l_cnt;
            end else if (ret_fire) begin
                frame_base_q <= st_top.base;
                frame_size_q <= st_top.size;
            end
        end
    end

    assign bus.frame_base    = frame_base_q;
    assign bus.next_base     = next_base_c;
    assign bus.depth         = st_count;
    assign bus.busy          = !idle;
    assign bus.done          = done_q;
    assign bus.err_overflow  = ovf_q;
    assign bus.err_underflow = unf_q;

endmodule

// File: doc/wasm_frame_setup.md
# wasm_frame_setup

Call-frame sequencer that sits directly upstream of the locals store. On a function call it allocates a new locals window, pops the call parameters off the operand stack into that window, and zero-fills the declared locals through the locals write port. On return it restores the caller's window. It keeps its own frame stack of base and size values and drives the locals read base (`frame_base`) for the execute stage.

## Interface
Parameters:
- `MAX_DEPTH`, default `CALL_STACK_DEPTH`: frame stack entries, excluding the root frame.
- `MAX_LOCALS`, default `LOCAL_COUNT*CALL_STACK_DEPTH`: size of the locals store in entries.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `call_valid`  in  1  call request
- `call_ready`  out  1  call accepted when `call_valid && call_ready`
- `call_param_count`  in  8  P, number of parameters
- `call_local_count`  in  8  L, number of declared non-parameter locals
- `call_types`  in  `valtype_t [0:31]`  type of declared local j at index j
- `ret_valid`  in  1  return request
- `ret_ready`  out  1  return accepted
- `pop_req`  out  1  operand-stack pop request
- `pop_valid`  in  1  `pop_data` valid; an entry is consumed when `pop_req && pop_valid`
- `pop_data`  in  `stack_entry_t`  top-of-stack entry
- `lw_en`  out  1  locals write strobe
- `lw_base_idx`  out  16  write base
- `lw_local_idx`  out  8  write index
- `lw_data`  out  `stack_entry_t`  write data
- `frame_base`  out  16  current frame base, feeding the locals read base
- `next_base`  out  16  `frame_base + current frame size`
- `depth`  out  8  number of live frames above the root
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle pulse when a call completes
- `err_overflow`  out  1  one-cycle pulse when a call is rejected
- `err_underflow`  out  1  one-cycle pulse when a return is rejected

## Operation
- **Root frame:** base 0, size 0.
- **State machine:** IDLE → POP → ZERO → DONE → IDLE.
- **Call acceptance.** `call_ready = (state==IDLE) && !ret_valid`.
  - On accept, latch `nb = next_base`, P, L, and `call_types`.
  - Go to POP if P>0, else ZERO if L>0, else DONE.
- **Call rejection.** A call is rejected if any of the following hold:
  - `depth == MAX_DEPTH`
  - `P+L > 32`
  - `nb+P+L > MAX_LOCALS`
  On rejection: register an `err_overflow` pulse, stay in IDLE, and change no frame state.
- **POP state:**
  - `pop_req = 1`.
  - Each consume writes `lw_en = 1`, `lw_base_idx = nb`, `lw_local_idx = r-1`, `lw_data = pop_data`, where r is the remaining count (initially P).
  - Then decrement r. The last parameter is written to index P-1 first.
  - When r reaches 0, go to ZERO if L>0, else DONE.
  - A cycle with `pop_valid` low stalls the sequence and produces no write.
- **ZERO state:**
  - One write per cycle for j = 0..L-1: `lw_local_idx = P+j`, `lw_data = {call_types[j], 64'h0}`.
  - After j = L-1, go to DONE.
- **DONE state:**
  - `done = 1`.
  - Push {old base, old size} onto the frame stack.
  - `frame_base <= nb`, size <= P+L, `depth <= depth+1`.
- **Return:**
  - `ret_ready = (state==IDLE) && depth>0`.
  - On accept, pop the frame stack; on the next cycle `frame_base` and size show the caller's values and `depth` is decremented.
  - `ret_valid` with `depth == 0`: `err_underflow` pulse, no other change.
  - Locals contents are not cleared on return.
- **Simultaneous call and return in IDLE:** return has priority, and `call_ready` is low that cycle.
- **Outputs outside active states:** `lw_*` and `pop_req` are 0 outside POP/ZERO. `lw_data` is 0 when `lw_en` is low.

## Timing
- **Reset values:**
  - state IDLE
  - `frame_base`, size, `next_base`, `depth`: 0
  - `pop_req`, `lw_en`, `done`, `busy`, errors: 0
  - frame stack: cleared
- **Reset behaviour:** reset asserted mid-call abandons the sequence immediately; partial locals writes are not undone.
- **Call latency:** accept at cycle T with no stalls:
  - POP writes in T+1..T+P
  - ZERO writes in T+P+1..T+P+L
  - `done` in T+P+L+1
  - new `frame_base` visible from T+P+L+2
- **Handshake timing:** `call_ready`, `ret_ready`, `pop_req` and the `lw_*` outputs are combinational from state. `done` and the errors are registered pulses.
- **Width rules:** `lw_local_idx` is 8 bits; P+L is computed in 9 bits for the >32 check; the base sum is computed in 17 bits.

## Structure
- Use `stack_entry_t`, `valtype_t`, `LOCAL_COUNT` and `CALL_STACK_DEPTH` from `wasm_pkg`.
- Add a `frame_state_t` enum and a `frame_rec_t {base[16], size[8]}` typedef to `wasm_pkg`.
- One sub-module, `wasm_frame_stack`: a LIFO of `frame_rec_t`, depth `MAX_DEPTH`, with push/pop/top, asynchronous active-low reset, and full/empty outputs.

## Test plan
- **Basic call:** stack top-first 7, 5 (i32), call P=2, L=1, `types[0]=i64` from root → writes idx1=7, idx0=5, idx2={i64,0} at base 0; `done` at T+4; `frame_base=0`, `next_base=3`, `depth=1`.
- **Nested call and return:** nested call P=1, L=0 → base 3, `next_base=4`, `depth=2`; a return then restores `frame_base=0`, `depth=1` one cycle later.
- **Pop stalls:** hold `pop_valid` low for 3 cycles mid-POP → no `lw_en` in those cycles; `done` is delayed by exactly 3 cycles.
- **Rejections:**
  - `depth==MAX_DEPTH` → `err_overflow` pulse, no `lw_en`, no state change.
  - P=20, L=13 → `err_overflow` pulse.
  - Return at `depth=0` → `err_underflow` pulse.
- **Priority:** `call_valid` and `ret_valid` high together in IDLE → only the return is taken, with `call_ready=0`; the call is accepted the following cycle.
- **Reset mid-call:** assert `rst_n=0` during ZERO → all outputs are at their reset values, then a clean call from root works.
